log_result_bcd: RTL and testbench



---
 rtl/calc_pkg.sv | 23 ++
 rtl/bcd_dabble_step.sv | 34 +++
 rtl/log_result_bcd.sv | 125 ++++++++++++
 tb/tb_log_result_bcd.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// | Package : calc_pkg                                                      |
// | Shared types and constants for the log-result BCD formatter.            |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int DIGITS   = 5;
  localparam int FRAC_MAX = 99999;
  localparam int STEPS    = 17;

  typedef logic [3:0] bcd_digit_t;

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_step.sv
// ---------------------------------------------------------------------------
// | Module  : bcd_dabble_step                                               |
// | One combinational add-3-then-shift iteration over a packed BCD field.   |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_dabble_step
  import calc_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                shift_in,
  output logic [4*DIGITS-1:0] bcd_out
);

  logic [4*DIGITS-1:0] w_adj;
  logic                w_unused_msb;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_t w_d;
      assign w_d              = bcd_in[4*i +: 4];
      assign w_adj[4*i +: 4]  = (w_d >= 4'd5) ? w_d + 4'd3 : w_d;
    end
  endgenerate

  // The top bit leaving the field is always zero for in-range inputs.
  assign {w_unused_msb, bcd_out} = {w_adj, shift_in};

endmodule

`default_nettype wire

// File: rtl/log_result_bcd.sv
// ---------------------------------------------------------------------------
// | Module  : log_result_bcd                                                |
// | Iterative binary-to-BCD formatter for the integer/fraction log result.  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module log_result_bcd
  import calc_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 17,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [INT_W-1:0]    int_in,
  input  logic [FRAC_W-1:0]   frac_in,
  output logic                busy,
  output logic                valid,
  output logic [4*DIGITS-1:0] int_bcd,
  output logic [4*DIGITS-1:0] frac_bcd,
  output logic [DIGITS-1:0]   int_blank,
  output logic                frac_ovf
);

  localparam int               c_cnt_w    = $clog2(STEPS);
  localparam logic [STEPS-1:0] c_frac_max = STEPS'(FRAC_MAX);
  localparam logic [DIGITS-1:0] c_blank_rst = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_count;
  logic [STEPS-1:0]    r_int_sr;
  logic [STEPS-1:0]    r_frac_sr;
  logic [4*DIGITS-1:0] r_int_acc;
  logic [4*DIGITS-1:0] r_frac_acc;
  logic                r_ovf;

  logic [STEPS-1:0]    w_frac_ext;
  logic                w_frac_sat;
  logic [4*DIGITS-1:0] w_int_next;
  logic [4*DIGITS-1:0] w_frac_next;
  logic [DIGITS-1:0]   w_blank;

  assign w_frac_ext = STEPS'(frac_in);
  assign w_frac_sat = (w_frac_ext > c_frac_max);

  bcd_dabble_step #(.DIGITS(DIGITS)) u_int_step (
    .bcd_in   (r_int_acc),
    .shift_in (r_int_sr[STEPS-1]),
    .bcd_out  (w_int_next)
  );

  bcd_dabble_step #(.DIGITS(DIGITS)) u_frac_step (
    .bcd_in   (r_frac_acc),
    .shift_in (r_frac_sr[STEPS-1]),
    .bcd_out  (w_frac_next)
  );

  // Blank a digit only while every more-significant digit is also zero.
  always_comb begin : p_blank
    logic zero_run;
    w_blank  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      zero_run   = zero_run & (w_int_next[4*i +: 4] == 4'd0);
      w_blank[i] = zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_int_sr   <= '0;
      r_frac_sr  <= '0;
      r_int_acc  <= '0;
      r_frac_acc <= '0;
      r_ovf      <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      int_bcd    <= '0;
      frac_bcd   <= '0;
      int_blank  <= c_blank_rst;
      frac_ovf   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_int_sr   <= STEPS'(int_in);
            r_frac_sr  <= w_frac_sat ? c_frac_max : w_frac_ext;
            r_ovf      <= w_frac_sat;
            r_int_acc  <= '0;
            r_frac_acc <= '0;
            r_count    <= '0;
            busy       <= 1'b1;
            r_state    <= CONVERT;
          end
        end
        CONVERT: begin
          r_int_acc  <= w_int_next;
          r_frac_acc <= w_frac_next;
          r_int_sr   <= r_int_sr << 1;
          r_frac_sr  <= r_frac_sr << 1;
          r_count    <= r_count + c_cnt_w'(1);
          if (r_count == c_cnt_w'(STEPS-1)) begin
            int_bcd   <= w_int_next;
            frac_bcd  <= w_frac_next;
            int_blank <= w_blank;
            frac_ovf  <= r_ovf;
            valid     <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_log_result_bcd.sv
// ---------------------------------------------------------------------------
// | Module  : tb_log_result_bcd                                             |
// | Directed self-checking bench for log_result_bcd.                        |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_log_result_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] int_in;
  logic [16:0] frac_in;
  logic        busy;
  logic        valid;
  logic [19:0] int_bcd;
  logic [19:0] frac_bcd;
  logic [4:0]  int_blank;
  logic        frac_ovf;

  int asserts = 0;
  int fails   = 0;

  log_result_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .int_in    (int_in),
    .frac_in   (frac_in),
    .busy      (busy),
    .valid     (valid),
    .int_bcd   (int_bcd),
    .frac_bcd  (frac_bcd),
    .int_blank (int_blank),
    .frac_ovf  (frac_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present start for one rising edge; returns at the negedge after acceptance.
  task automatic do_start(input logic [15:0] iv, input logic [16:0] fv);
    @(negedge clk);
    int_in  = iv;
    frac_in = fv;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Counts negedges until valid is seen; -1 if it never appears.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    int_in  = '0;
    frac_in = '0;
    repeat (3) @(negedge clk);
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    asserts++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    asserts++; if (int_bcd !== 20'h0) begin fails++; $display("FAIL reset_int_bcd got=%h exp=00000", int_bcd); end
    asserts++; if (frac_bcd !== 20'h0) begin fails++; $display("FAIL reset_frac_bcd got=%h exp=00000", frac_bcd); end
    asserts++; if (int_blank !== 5'b11110) begin fails++; $display("FAIL reset_blank got=%b exp=11110", int_blank); end
    asserts++; if (frac_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", frac_ovf); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    do_start(16'd12345, 17'd6789);
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_valid(n);
    asserts++; if (n !== 17) begin fails++; $display("FAIL basic_latency got=%0d exp=17", n); end
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    asserts++; if (int_bcd !== 20'h12345) begin fails++; $display("FAIL basic_int got=%h exp=12345", int_bcd); end
    asserts++; if (frac_bcd !== 20'h06789) begin fails++; $display("FAIL basic_frac got=%h exp=06789", frac_bcd); end
    asserts++; if (int_blank !== 5'b00000) begin fails++; $display("FAIL basic_blank got=%b exp=00000", int_blank); end
    asserts++; if (frac_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf got=%b exp=0", frac_ovf); end
    @(negedge clk);
    asserts++; if (int_bcd !== 20'h12345) begin fails++; $display("FAIL basic_hold got=%h exp=12345", int_bcd); end
  endtask

  task automatic test_ln10;
    int n;
    do_start(16'd2, 17'd30258);
    wait_valid(n);
    asserts++; if (n !== 17) begin fails++; $display("FAIL ln10_latency got=%0d exp=17", n); end
    asserts++; if (int_bcd !== 20'h00002) begin fails++; $display("FAIL ln10_int got=%h exp=00002", int_bcd); end
    asserts++; if (frac_bcd !== 20'h30258) begin fails++; $display("FAIL ln10_frac got=%h exp=30258", frac_bcd); end
    asserts++; if (int_blank !== 5'b11110) begin fails++; $display("FAIL ln10_blank got=%b exp=11110", int_blank); end
  endtask

  task automatic test_saturate;
    int n;
    do_start(16'd65535, 17'd120000);
    wait_valid(n);
    asserts++; if (n !== 17) begin fails++; $display("FAIL sat_latency got=%0d exp=17", n); end
    asserts++; if (int_bcd !== 20'h65535) begin fails++; $display("FAIL sat_int got=%h exp=65535", int_bcd); end
    asserts++; if (frac_bcd !== 20'h99999) begin fails++; $display("FAIL sat_frac got=%h exp=99999", frac_bcd); end
    asserts++; if (frac_ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf got=%b exp=1", frac_ovf); end
    asserts++; if (int_blank !== 5'b00000) begin fails++; $display("FAIL sat_blank got=%b exp=00000", int_blank); end
  endtask

  task automatic test_zero;
    int n;
    do_start(16'd0, 17'd0);
    wait_valid(n);
    asserts++; if (n !== 17) begin fails++; $display("FAIL zero_latency got=%0d exp=17", n); end
    asserts++; if (int_bcd !== 20'h0) begin fails++; $display("FAIL zero_int got=%h exp=00000", int_bcd); end
    asserts++; if (frac_bcd !== 20'h0) begin fails++; $display("FAIL zero_frac got=%h exp=00000", frac_bcd); end
    asserts++; if (int_blank !== 5'b11110) begin fails++; $display("FAIL zero_blank got=%b exp=11110", int_blank); end
    asserts++; if (frac_ovf !== 1'b0) begin fails++; $display("FAIL zero_ovf got=%b exp=0", frac_ovf); end
    @(negedge clk);
    asserts++; if (valid !== 1'b0) begin fails++; $display("FAIL zero_valid_pulse got=%b exp=0", valid); end
  endtask

  task automatic test_back_to_back;
    int n;
    do_start(16'd321, 17'd54321);
    repeat (4) @(negedge clk);
    int_in  = 16'd999;
    frac_in = 17'd11111;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_valid(n);
    asserts++; if (n !== 12) begin fails++; $display("FAIL ignore_latency got=%0d exp=12", n); end
    asserts++; if (int_bcd !== 20'h00321) begin fails++; $display("FAIL ignore_int got=%h exp=00321", int_bcd); end
    asserts++; if (frac_bcd !== 20'h54321) begin fails++; $display("FAIL ignore_frac got=%h exp=54321", frac_bcd); end
    asserts++; if (int_blank !== 5'b11000) begin fails++; $display("FAIL ignore_blank got=%b exp=11000", int_blank); end
    // Raise start in the valid cycle: the FSM is idle and must accept it.
    int_in  = 16'd7008;
    frac_in = 17'd90001;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    asserts++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_valid(n);
    asserts++; if (n !== 17) begin fails++; $display("FAIL b2b_latency got=%0d exp=17", n); end
    asserts++; if (int_bcd !== 20'h07008) begin fails++; $display("FAIL b2b_int got=%h exp=07008", int_bcd); end
    asserts++; if (frac_bcd !== 20'h90001) begin fails++; $display("FAIL b2b_frac got=%h exp=90001", frac_bcd); end
    asserts++; if (int_blank !== 5'b10000) begin fails++; $display("FAIL b2b_blank got=%b exp=10000", int_blank); end
  endtask

  task automatic test_reset_mid;
    int n;
    int seen;
    do_start(16'd4321, 17'd100001);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    asserts++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    asserts++; if (int_bcd !== 20'h0) begin fails++; $display("FAIL abort_int got=%h exp=00000", int_bcd); end
    asserts++; if (frac_bcd !== 20'h0) begin fails++; $display("FAIL abort_frac got=%h exp=00000", frac_bcd); end
    asserts++; if (int_blank !== 5'b11110) begin fails++; $display("FAIL abort_blank got=%b exp=11110", int_blank); end
    asserts++; if (frac_ovf !== 1'b0) begin fails++; $display("FAIL abort_ovf got=%b exp=0", frac_ovf); end
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    asserts++; if (seen !== 0) begin fails++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
    do_start(16'd40, 17'd500);
    wait_valid(n);
    asserts++; if (n !== 17) begin fails++; $display("FAIL post_latency got=%0d exp=17", n); end
    asserts++; if (int_bcd !== 20'h00040) begin fails++; $display("FAIL post_int got=%h exp=00040", int_bcd); end
    asserts++; if (frac_bcd !== 20'h00500) begin fails++; $display("FAIL post_frac got=%h exp=00500", frac_bcd); end
    asserts++; if (int_blank !== 5'b11100) begin fails++; $display("FAIL post_blank got=%b exp=11100", int_blank); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ln10;
    test_saturate;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

`default_nettype wire
